// File: rtl/pd_input_conditioner_if.sv
// Signal bundle between the photodiode comparator side and the conditioner.
// The master drives the raw level and count clear; the slave is the conditioner.
interface pd_input_conditioner_if #(
    parameter int CNT_W = 16
);
    logic             pd_raw;
    logic             clr_count;
    logic             pd_sensor_data;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] event_count;

    modport master (
        output pd_raw,
        output clr_count,
        input  pd_sensor_data,
        input  rise_pulse,
        input  fall_pulse,
        input  event_count
    );

    modport slave (
        input  pd_raw,
        input  clr_count,
        output pd_sensor_data,
        output rise_pulse,
        output fall_pulse,
        output event_count
    );
endinterface

// File: rtl/pd_input_conditioner.sv
// Photodiode front end: 2-flop synchroniser, debounce FSM, edge pulses and a
// saturating count of accepted rising events. All outputs are registered.
module pd_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input logic                    clk,
    input logic                    reset_n,
    pd_input_conditioner_if.slave  bus
);
    localparam int QW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [QW-1:0] QMAX = QW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE_LOW  = 2'd0;
    localparam logic [1:0] QUAL_HIGH = 2'd1;
    localparam logic [1:0] IDLE_HIGH = 2'd2;
    localparam logic [1:0] QUAL_LOW  = 2'd3;

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic [1:0]       state_q, state_d;
    logic [QW-1:0]    qcnt_q, qcnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = bus.pd_raw;
        s2_d    = s1_q;
        state_d = state_q;
        qcnt_d  = qcnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE_LOW: begin
                if (s2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_HIGH;
                        level_d = 1'b1;
                        rise_d  = 1'b1;
                        qcnt_d  = '0;
                    end else begin
                        state_d = QUAL_HIGH;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            QUAL_HIGH: begin
                if (!s2_q) begin
                    state_d = IDLE_LOW;
                    qcnt_d  = '0;
                end else if (qcnt_q == QMAX) begin
                    state_d = IDLE_HIGH;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
            IDLE_HIGH: begin
                if (!s2_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = IDLE_LOW;
                        level_d = 1'b0;
                        fall_d  = 1'b1;
                        qcnt_d  = '0;
                    end else begin
                        state_d = QUAL_LOW;
                        qcnt_d  = QW'(1);
                    end
                end
            end
            default: begin
                if (s2_q) begin
                    state_d = IDLE_HIGH;
                    qcnt_d  = '0;
                end else if (qcnt_q == QMAX) begin
                    state_d = IDLE_LOW;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + QW'(1);
                end
            end
        endcase

        // Counting follows the accept decision so a clear on the same edge still records it.
        if (bus.clr_count) begin
            cnt_d = rise_d ? CNT_W'(1) : '0;
        end else if (rise_d && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= IDLE_LOW;
            qcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            qcnt_q  <= qcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pd_sensor_data = level_q;
    assign bus.rise_pulse     = rise_q;
    assign bus.fall_pulse     = fall_q;
    assign bus.event_count    = cnt_q;
endmodule

// File: tb/tb_pd_input_conditioner.sv
// Directed and random checks of pd_input_conditioner against a run-length
// model of the debounce rule (DEBOUNCE_CYCLES=4, CNT_W=4).
module tb_pd_input_conditioner;
    localparam int DC   = 4;
    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    // Model: two-stage delay of pd_raw, plus the length of the current run of
    // synced samples disagreeing with the accepted level.
    logic m_s1 = 1'b0, m_s2 = 1'b0, m_level = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int   m_run = 0;
    int   m_cnt = 0;

    pd_input_conditioner_if #(.CNT_W(CW)) bus ();

    pd_input_conditioner #(.DEBOUNCE_CYCLES(DC), .CNT_W(CW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic r, f;
        @(posedge clk);
        r = 1'b0;
        f = 1'b0;
        if (!reset_n) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0; m_run = 0; m_cnt = 0;
        end else begin
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == DC) begin
                    m_level = !m_level;
                    r = m_level;
                    f = !m_level;
                    m_run = 0;
                end
            end else begin
                m_run = 0;
            end
            if (bus.clr_count) m_cnt = r ? 1 : 0;
            else if (r && m_cnt < MAXC) m_cnt++;
            m_s2 = m_s1;
            m_s1 = bus.pd_raw;
        end
        m_rise = r;
        m_fall = f;
        #1;
        check("model_level", int'(bus.pd_sensor_data), int'(m_level));
        check("model_rise", int'(bus.rise_pulse), int'(m_rise));
        check("model_fall", int'(bus.fall_pulse), int'(m_fall));
        check("model_count", int'(bus.event_count), m_cnt);
    endtask

    task automatic hold(input logic v, input int n);
        bus.pd_raw = v;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.pd_raw    = 1'b1;
        bus.clr_count = 1'b0;
        reset_n       = 1'b0;

        // 1. reset with pd_raw high, then 6 edges to accept
        hold(1'b1, 2);
        check("rst_level", int'(bus.pd_sensor_data), 0);
        check("rst_rise", int'(bus.rise_pulse), 0);
        check("rst_fall", int'(bus.fall_pulse), 0);
        check("rst_count", int'(bus.event_count), 0);
        reset_n = 1'b1;
        hold(1'b1, 5);
        check("rst_rel_edge5", int'(bus.pd_sensor_data), 0);
        hold(1'b1, 1);
        check("rst_rel_edge6", int'(bus.pd_sensor_data), 1);

        // 2. step 0->1 from a cleared count
        bus.clr_count = 1'b1;
        hold(1'b0, 1);
        bus.clr_count = 1'b0;
        hold(1'b0, 20);
        check("step_pre_count", int'(bus.event_count), 0);
        hold(1'b1, 5);
        check("step_edge5", int'(bus.pd_sensor_data), 0);
        hold(1'b1, 1);
        check("step_edge6", int'(bus.pd_sensor_data), 1);
        check("step_rise", int'(bus.rise_pulse), 1);
        check("step_count", int'(bus.event_count), 1);
        hold(1'b1, 1);
        check("step_rise_end", int'(bus.rise_pulse), 0);
        hold(1'b1, 13);

        // 3. 3-cycle glitch rejected, 4-cycle pulse accepted
        hold(1'b0, 20);
        hold(1'b1, 3);
        hold(1'b0, 12);
        check("glitch3_level", int'(bus.pd_sensor_data), 0);
        check("glitch3_count", int'(bus.event_count), 1);
        hold(1'b1, 4);
        hold(1'b0, 2);
        check("pulse4_level", int'(bus.pd_sensor_data), 1);
        check("pulse4_count", int'(bus.event_count), 2);

        // 4. fall from high
        hold(1'b1, 20);
        hold(1'b0, 5);
        check("fall_edge5", int'(bus.fall_pulse), 0);
        hold(1'b0, 1);
        check("fall_edge6", int'(bus.fall_pulse), 1);
        check("fall_level", int'(bus.pd_sensor_data), 0);
        check("fall_count", int'(bus.event_count), 2);
        hold(1'b0, 1);
        check("fall_end", int'(bus.fall_pulse), 0);

        // 5. saturation then clear coincident with an accept
        bus.clr_count = 1'b1;
        hold(1'b0, 1);
        bus.clr_count = 1'b0;
        for (int k = 0; k < 17; k++) begin
            hold(1'b1, 8);
            hold(1'b0, 8);
        end
        check("sat_count", int'(bus.event_count), MAXC);
        hold(1'b1, 5);
        bus.clr_count = 1'b1;
        tick();
        bus.clr_count = 1'b0;
        check("clr_accept_count", int'(bus.event_count), 1);
        check("clr_accept_rise", int'(bus.rise_pulse), 1);
        hold(1'b1, 5);

        // 6. reset while qualifying high with qcnt=3
        hold(1'b0, 20);
        hold(1'b1, 5);
        reset_n = 1'b0;
        tick();
        check("midq_level", int'(bus.pd_sensor_data), 0);
        check("midq_rise", int'(bus.rise_pulse), 0);
        check("midq_count", int'(bus.event_count), 0);
        reset_n = 1'b1;
        hold(1'b1, 5);
        check("midq_requal5", int'(bus.pd_sensor_data), 0);
        hold(1'b1, 1);
        check("midq_requal6", int'(bus.pd_sensor_data), 1);
        check("midq_requal_rise", int'(bus.rise_pulse), 1);

        // random runs of pd_raw with occasional clear and reset
        for (int k = 0; k < 150; k++) begin
            bus.clr_count = ($urandom_range(15) == 0);
            reset_n       = ($urandom_range(60) != 0);
            hold(1'($urandom_range(1)), int'($urandom_range(1, 7)));
        end
        bus.clr_count = 1'b0;
        reset_n = 1'b1;
        hold(1'b0, 10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
